seq_signed_mult: RTL and testbench

- Iterative (multi-cycle) signed two's-complement multiplier.
- Captures operands A and B, computes the full-width 2*WIDTH product one radix-2 Booth step per clock, then presents the result on a registered output.
- Used in datapaths where area matters more than latency; a pipelined/array multiplier is the alternative.

---
 rtl/seq_mult_pkg.sv | 19 +
 rtl/seq_mult_booth_step.sv | 36 +++
 rtl/seq_signed_mult.sv | 105 ++++++++++
 tb/tb_seq_signed_mult.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the iterative Booth multiplier.
// Optional done output is enabled with SEQ_MULT_DONE_EN.
package seq_mult_pkg;

  localparam int SEQ_MULT_WIDTH = 32;

  localparam int SEQ_MULT_CNT_W = $clog2(SEQ_MULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult_booth_step.sv
// One radix-2 Booth step: add/sub the multiplicand into the
// upper half, then arithmetic-shift {acc, mplier, q(-1)} right.
module seq_mult_booth_step
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic             qm1_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] mplier_o,
  output logic             qm1_o
);

  logic [WIDTH:0] mc_ext;
  logic [WIDTH:0] sum;

  // One extra bit keeps -2^(WIDTH-1) add/sub from overflowing.
  assign mc_ext = {mcand_i[WIDTH-1], mcand_i};

  always_comb begin
    sum = acc_i;
    unique case ({mplier_i[0], qm1_i})
      2'b01:   sum = acc_i + mc_ext;
      2'b10:   sum = acc_i - mc_ext;
      default: sum = acc_i;
    endcase
  end

  assign acc_o    = {sum[WIDTH], sum[WIDTH:1]};
  assign mplier_o = {sum[0], mplier_i[WIDTH-1:1]};
  assign qm1_o    = mplier_i[0];

endmodule

// File: rtl/seq_signed_mult.sv
// Iterative signed multiplier, one Booth step per enabled clock.
// Define SEQ_MULT_DONE_EN to add the registered done output.
module seq_signed_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] OUT
`ifdef SEQ_MULT_DONE_EN
  ,
  output logic               done
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH:0]     acc_q;
  logic               qm1_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] out_q;
  logic               done_q;

  logic [WIDTH:0]     acc_d;
  logic [WIDTH-1:0]   mplier_d;
  logic               qm1_d;

  seq_mult_booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .qm1_i    (qm1_q),
    .acc_o    (acc_d),
    .mplier_o (mplier_d),
    .qm1_o    (qm1_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) begin
            mcand_q  <= A;
            mplier_q <= B;
            acc_q    <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= CW'(WIDTH);
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (en) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              out_q   <= {acc_d[WIDTH-1:0], mplier_d};
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (!en) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign OUT = out_q;

`ifdef SEQ_MULT_DONE_EN
  assign done = done_q;
`else
  logic unused_done;
  assign unused_done = done_q;
`endif

endmodule

// File: tb/tb_seq_signed_mult.sv
// Randomized and directed checks of seq_signed_mult against
// a plain arithmetic product model.
module tb_seq_signed_mult;

  localparam int W = 32;

  logic            clk;
  logic            rst;
  logic            en;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic [2*W-1:0]  OUT;
`ifdef SEQ_MULT_DONE_EN
  logic            done;
`endif

  int n_tests;
  int n_fail;
  logic [2*W-1:0] out_model;

  seq_signed_mult #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .A   (A),
    .B   (B),
    .OUT (OUT)
`ifdef SEQ_MULT_DONE_EN
    ,
    .done (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_model = '0;
    chk("reset_out", OUT, 64'd0);
`ifdef SEQ_MULT_DONE_EN
    chk("reset_done", {63'd0, done}, 64'd0);
`endif
  endtask

  // Full operation; optional pause of plen cycles before step pat.
  task automatic op(input string tag,
                    input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input int pat,
                    input int plen);
    logic [63:0] exp;
    exp = prod(a, b);
    @(negedge clk);
    A  = a;
    B  = b;
    en = 1'b1;
    @(posedge clk);
    for (int s = 1; s <= W; s++) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
      if (s == pat) begin
        en = 1'b0;
        repeat (plen) @(negedge clk);
        en = 1'b1;
      end
      if (s == W) begin
        chk({tag, "_early"}, OUT, out_model);
`ifdef SEQ_MULT_DONE_EN
        chk({tag, "_done_early"}, {63'd0, done}, 64'd0);
`endif
      end
      @(posedge clk);
    end
    @(negedge clk);
    out_model = exp;
    chk(tag, OUT, exp);
`ifdef SEQ_MULT_DONE_EN
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
`endif
    @(negedge clk);
    chk({tag, "_hold"}, OUT, exp);
`ifdef SEQ_MULT_DONE_EN
    chk({tag, "_done_hold"}, {63'd0, done}, 64'd1);
`endif
    en = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, OUT, exp);
`ifdef SEQ_MULT_DONE_EN
    chk({tag, "_done_idle"}, {63'd0, done}, 64'd0);
`endif
  endtask

  task automatic abort_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input int steps);
    @(negedge clk);
    A  = a;
    B  = b;
    en = 1'b1;
    @(posedge clk);
    repeat (steps) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    out_model = '0;
    chk("abort_out", OUT, 64'd0);
`ifdef SEQ_MULT_DONE_EN
    chk("abort_done", {63'd0, done}, 64'd0);
`endif
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t dir[$];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    out_model = '0;
    rst = 1'b0;
    en  = 1'b0;
    A   = '0;
    B   = '0;

    do_reset();
    op("first", 32'd12, -32'sd32, 0, 0);

    dir.push_back('{32'd5, 32'd15});
    dir.push_back('{-32'sd51, -32'sd4});
    dir.push_back('{-32'sd25, -32'sd60});
    dir.push_back('{32'd0, 32'd1234});
    dir.push_back('{32'd1, 32'd12});
    dir.push_back('{-32'sd12, 32'd72});
    dir.push_back('{32'd13, 32'd20});
    dir.push_back('{32'h8000_0000, 32'h8000_0000});
    dir.push_back('{32'h8000_0000, 32'd1});
    dir.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF});
    dir.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF});
    foreach (dir[i]) begin
      do_reset();
      op($sformatf("dir%0d", i), dir[i].a, dir[i].b, 0, 0);
    end

    op("pause", -32'sd1234567, 32'd7654321, 9, 10);

    abort_op(32'h1234_5678, 32'h9ABC_DEF0, 15);
    op("after_abort", 32'd7, -32'sd3, 0, 0);

    op("restart", 32'd100, -32'sd100, 0, 0);

    for (int i = 0; i < 20; i++) begin
      int pat;
      pat = (i % 3 == 0) ? int'($urandom_range(1, W)) : 0;
      op($sformatf("rnd%0d", i), $urandom, $urandom, pat,
         int'($urandom_range(1, 5)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
